// File: rtl/sixteenbit_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: default geometry and FSM state encoding.
package sixteenbit_serial_subtractor_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned DIGIT_DEF  = 4;
  localparam int unsigned NSLICE_DEF = WIDTH_DEF / DIGIT_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a 1-bit counter to be legal.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(NSLICE_DEF);

endpackage

// File: rtl/sixteenbit_serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. Ovf exists only with SIXTEENBIT_SERIAL_SUB_OVF_EN.
interface sixteenbit_serial_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
  logic             Ovf;

  modport master (output Start, X, Y, Bin, input Busy, Done, Diff, Bout, Ovf);
  modport slave  (input Start, X, Y, Bin, output Busy, Done, Diff, Bout, Ovf);
`else
  modport master (output Start, X, Y, Bin, input Busy, Done, Diff, Bout);
  modport slave  (input Start, X, Y, Bin, output Busy, Done, Diff, Bout);
`endif
endinterface

// File: rtl/sixteenbit_serial_subtractor_fourbit_borrow_ripple.sv
// Combinational DIGIT-bit borrow-ripple subtractor slice built from full-subtractor cells.
module fourbit_borrow_ripple #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Bin,
  output logic [DIGIT-1:0] D,
  output logic             Bout
);

  logic borrow;

  always_comb begin
    D      = '0;
    borrow = Bin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      D[i]   = A[i] ^ B[i] ^ borrow;
      borrow = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow);
    end
    Bout = borrow;
  end

endmodule

// File: rtl/sixteenbit_serial_subtractor.sv
// Digit-serial X - Y - Bin: one DIGIT-bit slice per clock with a registered borrow.
// Optional Ovf output is enabled by defining SIXTEENBIT_SERIAL_SUB_OVF_EN.
module sixteenbit_serial_subtractor
  import sixteenbit_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input logic                          Clk,
  input logic                          Reset,
  sixteenbit_serial_subtractor_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CNT_W  = cnt_width(NSLICE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic [DIGIT-1:0]   slice_diff;
  logic               slice_borrow;
  logic               accept;
  logic               last_slice;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
  logic               xs_q, xs_d;
  logic               ys_q, ys_d;
  logic               ovf_q, ovf_d;
`endif

  // Operands are shifted right each cycle so the slice always sees the low digit.
  fourbit_borrow_ripple #(.DIGIT(DIGIT)) u_slice (
    .A    (x_q[DIGIT-1:0]),
    .B    (y_q[DIGIT-1:0]),
    .Bin  (borrow_q),
    .D    (slice_diff),
    .Bout (slice_borrow)
  );

  assign accept     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.Start;
  assign last_slice = (state_q == ST_RUN) && (cnt_q == CNT_W'(NSLICE - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      shadow_q <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      shadow_q <= shadow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.Start) state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: state_d = bus.Start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    shadow_d = shadow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
    xs_d     = xs_q;
    ys_d     = ys_q;
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      cnt_d    = '0;
      x_d      = bus.X;
      y_d      = bus.Y;
      borrow_d = bus.Bin;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
      xs_d     = bus.X[WIDTH-1];
      ys_d     = bus.Y[WIDTH-1];
`endif
    end else if (state_q == ST_RUN) begin
      cnt_d    = CNT_W'(cnt_q + 1'b1);
      x_d      = x_q >> DIGIT;
      y_d      = y_q >> DIGIT;
      borrow_d = slice_borrow;
      // New digit enters at the top; after NSLICE shifts slice 0 sits at the bottom.
      shadow_d = (shadow_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));
      if (last_slice) begin
        diff_d = shadow_d;
        bout_d = slice_borrow;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
        ovf_d  = (xs_q ^ ys_q) & (slice_diff[DIGIT-1] ^ xs_q);
`endif
      end
    end
  end

  always_comb begin
    bus.Busy = (state_q == ST_RUN);
    bus.Done = (state_q == ST_DONE);
    bus.Diff = diff_q;
    bus.Bout = bout_q;
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
    bus.Ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_sixteenbit_serial_subtractor.sv
// Directed and random checks of the digit-serial subtractor (16-bit, 4-bit digits).
module tb_sixteenbit_serial_subtractor;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   n_done;
  int   seen_done;
  logic [15:0] rx, ry;
  logic        rb;
  logic [16:0] exp17;

  sixteenbit_serial_subtractor_if #(.WIDTH(16)) bus ();

  sixteenbit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request; returns #1 after the accepting edge with junk on the operand inputs.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic b);
    bus.X     = x;
    bus.Y     = y;
    bus.Bin   = b;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.X     = 16'(~x);
    bus.Y     = 16'($urandom);
    bus.Bin   = ~b;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.Done && cycles < 12) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_done    = 0;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    bus.Bin   = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_diff", 32'(bus.Diff), 32'd0);
    check("rst_bout", 32'(bus.Bout), 32'd0);
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
    Reset = 1'b0;
    tick();

    // Basic: 1234 - 0234 = 1000, Busy for exactly four cycles.
    start_op(16'h1234, 16'h0234, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("basic_busy", 32'({bus.Busy, bus.Done}), 32'b10);
      tick();
    end
    check("basic_done", 32'({bus.Busy, bus.Done}), 32'b01);
    check("basic_diff", 32'(bus.Diff), 32'h1000);
    check("basic_bout", 32'(bus.Bout), 32'd0);
    tick();
    check("basic_done_pulse", 32'(bus.Done), 32'd0);
    check("basic_hold", 32'(bus.Diff), 32'h1000);

    // Wrap-around: 0 - 1 and 0 - 0 - 1.
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(cyc);
    check("wrap_lat", 32'(cyc), 32'd4);
    check("wrap_res", 32'({bus.Bout, bus.Diff}), 32'h1FFFF);
    tick();
    start_op(16'h0000, 16'h0000, 1'b1);
    wait_done(cyc);
    check("wrapb_res", 32'({bus.Bout, bus.Diff}), 32'h1FFFF);
    tick();

    // Signed overflow: 8000 - 0001 - 1 = 7FFE.
    start_op(16'h8000, 16'h0001, 1'b1);
    wait_done(cyc);
    check("ovf_res", 32'({bus.Bout, bus.Diff}), 32'h07FFE);
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
    check("ovf_flag", 32'(bus.Ovf), 32'd1);
`endif
    tick();
`ifdef SIXTEENBIT_SERIAL_SUB_OVF_EN
    check("ovf_hold", 32'(bus.Ovf), 32'd1);
`endif

    // Start while busy is ignored; then Start during Done is accepted.
    start_op(16'h00FF, 16'h000F, 1'b0);
    tick();
    bus.Start = 1'b1;
    bus.X     = 16'h1111;
    bus.Y     = 16'h2222;
    bus.Bin   = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    check("busy_ign_busy", 32'(bus.Busy), 32'd1);
    tick();
    check("busy_ign_done", 32'(bus.Done), 32'd1);
    check("busy_ign_diff", 32'({bus.Bout, bus.Diff}), 32'h000F0);
    start_op(16'h0005, 16'h0003, 1'b0);
    check("b2b_busy", 32'({bus.Busy, bus.Done}), 32'b10);
    check("b2b_hold", 32'(bus.Diff), 32'h00F0);
    tick();
    tick();
    tick();
    check("b2b_not_yet", 32'(bus.Done), 32'd0);
    tick();
    check("b2b_done", 32'(bus.Done), 32'd1);
    check("b2b_diff", 32'({bus.Bout, bus.Diff}), 32'h00002);
    tick();

    // Reset at RUN cnt=2 discards the operation.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_state", 32'({bus.Busy, bus.Done}), 32'b00);
    check("midrst_out", 32'({bus.Bout, bus.Diff}), 32'h00000);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Done) seen_done++;
      tick();
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_idle", 32'(bus.Busy), 32'd0);

    // Random back-to-back regression: each Start issued during the previous Done.
    for (int i = 0; i < 10000; i++) begin
      rx    = 16'($urandom);
      ry    = 16'($urandom);
      rb    = 1'($urandom_range(0, 1));
      exp17 = {1'b0, rx} - {1'b0, ry} - {16'b0, rb};
      start_op(rx, ry, rb);
      wait_done(cyc);
      if (bus.Done) n_done++;
      check("rand_lat", 32'(cyc), 32'd4);
      check("rand_res", 32'({bus.Bout, bus.Diff}), 32'(exp17));
    end
    tick();
    check("rand_done_count", 32'(n_done), 32'd10000);
    check("rand_idle", 32'({bus.Busy, bus.Done}), 32'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
